// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/shift/compare ops, iterative shift-add mul and restoring divider.
// Divider ops (divu/remu) are built only when ALU_SEQ_DIV_EN is defined; otherwise they return 0.
module alu_seq #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           alu_op,
    input  logic [BUS_WIDTH-1:0] src_a,
    input  logic [BUS_WIDTH-1:0] src_b,
    output logic                 ready,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] alu_result,
    output logic                 zero
);

    localparam int SHW = $clog2(BUS_WIDTH);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {K_MUL, K_DIVU, K_REMU} kind_t;

    state_t               state, next_state;
    kind_t                kind;
    logic [SHW-1:0]       cnt;
    logic [BUS_WIDTH-1:0] acc, opa, opb;
    logic [BUS_WIDTH-1:0] acc_step, opa_step, opb_step, final_res;
    logic [BUS_WIDTH-1:0] quick_res;
    logic [SHW-1:0]       shamt;
    logic                 is_long;
    kind_t                start_kind;

    assign shamt = src_b[SHW-1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        is_long    = 1'b0;
        start_kind = K_MUL;
        case (alu_op)
            4'b1010: is_long = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            4'b1011: begin is_long = 1'b1; start_kind = K_DIVU; end
            4'b1100: begin is_long = 1'b1; start_kind = K_REMU; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        quick_res = '0;
        case (alu_op)
            4'b0000: quick_res = src_a + src_b;
            4'b0001: quick_res = src_a - src_b;
            4'b0010: quick_res = src_a | src_b;
            4'b0011: quick_res = src_a & src_b;
            4'b0100: quick_res = src_a ^ src_b;
            4'b0101: quick_res = {{(BUS_WIDTH-1){1'b0}}, src_a < src_b};
            4'b0110: quick_res = {{(BUS_WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'b0111: quick_res = src_a << shamt;
            4'b1000: quick_res = src_a >> shamt;
            4'b1001: quick_res = BUS_WIDTH'($signed(src_a) >>> shamt);
            default: quick_res = '0;
        endcase
    end

`ifdef ALU_SEQ_DIV_EN
    logic [BUS_WIDTH:0] rem_sh, rem_diff;
    logic               rem_ge;
`endif

    // One iteration: mul uses acc=partial product, opa=multiplicand, opb=multiplier;
    // div uses acc=partial remainder, opa=dividend/quotient shift register, opb=divisor.
    always_comb begin
        acc_step = acc + (opb[0] ? opa : '0);
        opa_step = opa << 1;
        opb_step = opb >> 1;
`ifdef ALU_SEQ_DIV_EN
        rem_sh   = {acc, opa[BUS_WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opb};
        rem_ge   = rem_sh >= {1'b0, opb};
        if (kind != K_MUL) begin
            acc_step = rem_ge ? rem_diff[BUS_WIDTH-1:0] : rem_sh[BUS_WIDTH-1:0];
            opa_step = {opa[BUS_WIDTH-2:0], rem_ge};
            opb_step = opb;
        end
`endif
        case (kind)
            K_DIVU:  final_res = opa_step;
            default: final_res = acc_step;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && is_long) next_state = BUSY;
            BUSY:    if (cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind       <= K_MUL;
            cnt        <= '0;
            acc        <= '0;
            opa        <= '0;
            opb        <= '0;
            alu_result <= '0;
            zero       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && is_long) begin
                    kind <= start_kind;
                    cnt  <= SHW'(BUS_WIDTH - 1);
                    acc  <= '0;
                    opa  <= src_a;
                    opb  <= src_b;
                end else if (start) begin
                    alu_result <= quick_res;
                    zero       <= (quick_res == '0);
                    done       <= 1'b1;
                end
            end else begin
                acc <= acc_step;
                opa <= opa_step;
                opb <= opb_step;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    alu_result <= final_res;
                    zero       <= (final_res == '0);
                    done       <= 1'b1;
                end
            end
        end
    end

endmodule
